alien_fire_scheduler: RTL and testbench

ALIEN_FIRE_SCHEDULER -- requirements
Module: alien_fire_scheduler

---
 rtl/alien_pkg.sv | 43 ++++
 rtl/lfsr8.sv | 24 ++
 rtl/alien_fire_scheduler.sv | 151 +++++++++++++++
 tb/tb_alien_fire_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_pkg.sv
// Shared definitions for the alien fire scheduler: FSM states, grid
// geometry, LFSR seed and small grid-decoding helpers.
package alien_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    BOTTOM = 2'd2,
    LAUNCH = 2'd3
  } fire_state_e;

  // Alien grid geometry; alive mask bit index is row*ALIEN_COLUMN+col.
  localparam int ALIEN_ROW    = 4;
  localparam int ALIEN_COLUMN = 8;

  // Power-up and reset value of the random source.
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Gather the row bits of one column, bit r = alien at row r.
  function automatic logic [ALIEN_ROW-1:0] column_bits(
    input logic [ALIEN_ROW*ALIEN_COLUMN-1:0] alive,
    input logic [2:0]                        col
  );
    logic [ALIEN_ROW-1:0] bits;
    bits = '0;
    for (int r = 0; r < ALIEN_ROW; r++) begin
      bits[r] = alive[r*ALIEN_COLUMN + int'(col)];
    end
    return bits;
  endfunction

  // Highest-numbered set row, i.e. the alien closest to the player.
  function automatic logic [1:0] bottom_row(input logic [ALIEN_ROW-1:0] bits);
    logic [1:0] row;
    row = '0;
    for (int r = 0; r < ALIEN_ROW; r++) begin
      if (bits[r]) row = 2'(r);
    end
    return row;
  endfunction

endpackage : alien_pkg

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, free-running
// one step per clock; picks the starting column for each scan.
module lfsr8
  import alien_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);

  logic feedback;

  // Taps at stages 8, 6, 5 and 4 give the maximal 255-state sequence.
  assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

  // Shift left every cycle, feedback into bit 0.
  always_ff @(posedge clk) begin
    if (reset) value <= SEED;
    else       value <= {value[6:0], feedback};
  end

endmodule : lfsr8

// File: rtl/alien_fire_scheduler.sv
// Alien fire scheduler: once per frame, when the cooldown has expired and a
// shot slot is free, scans for an occupied column starting at a random one,
// picks its bottom alien and emits a one-cycle spawn pulse with the shot's
// start position. Shot motion belongs to the shot movement blocks.
module alien_fire_scheduler
  import alien_pkg::*;
#(
  parameter int NUM_SLOTS       = 2,
  parameter int COOLDOWN_FRAMES = 20,
  parameter int COL_PITCH       = 64,
  parameter int ROW_PITCH       = 32,
  parameter int SHOT_X_OFFSET   = 31,
  parameter int SHOT_Y_OFFSET   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 playGame,
  input  logic [31:0]          alienAlive,
  input  logic signed [10:0]   gridX,
  input  logic signed [10:0]   gridY,
  input  logic [NUM_SLOTS-1:0] slotAlive,
  output logic [NUM_SLOTS-1:0] launch,
  output logic signed [10:0]   launchX,
  output logic signed [10:0]   launchY,
  output logic                 busy
);

  // Cooldown counter wide enough to hold COOLDOWN_FRAMES.
  localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(COOLDOWN_FRAMES);

  fire_state_e             state;
  logic [CD_W-1:0]         cooldown;
  logic [2:0]              col_ptr;
  logic [2:0]              scan_cnt;
  logic [7:0]              lfsr_value;
  logic [ALIEN_ROW-1:0]    col_bits;
  logic [1:0]              row_sel;
  logic [NUM_SLOTS-1:0]    slot_sel;
  logic signed [10:0]      spawn_x;
  logic signed [10:0]      spawn_y;
  logic                    unused_lfsr_bits;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  // Only the low three bits choose a column; the rest stay internal.
  assign unused_lfsr_bits = ^lfsr_value[7:3];

  // Occupancy of the column under the pointer and its bottom alien.
  assign col_bits = column_bits(alienAlive, col_ptr);
  assign row_sel  = bottom_row(col_bits);

  // Spawn position: sums carried at 13 bits, then wrapped to 11 bits.
  assign spawn_x = 11'({{2{gridX[10]}}, gridX}
                       + 13'(int'(col_ptr) * COL_PITCH)
                       + 13'(SHOT_X_OFFSET));
  assign spawn_y = 11'({{2{gridY[10]}}, gridY}
                       + 13'(int'(row_sel) * ROW_PITCH)
                       + 13'(SHOT_Y_OFFSET));

  // Lowest-index free slot as a one-hot vector, zero when all are busy.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    slot_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slotAlive[i] && (slot_sel == '0)) slot_sel[i] = 1'b1;
    end
  end

  // Scheduler FSM with cooldown and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      launch   <= '0;
      launchX  <= '0;
      launchY  <= '0;
      busy     <= 1'b0;
      cooldown <= CD_RELOAD;
      col_ptr  <= '0;
      scan_cnt <= '0;
    end else begin
      launch <= '0;

      // NOTE: non-blocking assignments; when a later branch also assigns
      // cooldown (launch reload) the last assignment in program order wins.
      if (!playGame) begin
        cooldown <= CD_RELOAD;
      end else if (startOfFrame && (cooldown != '0)) begin
        cooldown <= cooldown - CD_W'(1);
      end

      if (!playGame) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (startOfFrame && (cooldown == '0) && !(&slotAlive)) begin
              state    <= SCAN;
              busy     <= 1'b1;
              col_ptr  <= lfsr_value[2:0];
              scan_cnt <= '0;
            end
          end

          SCAN: begin
            if (|col_bits) begin
              state <= BOTTOM;
            end else begin
              col_ptr  <= col_ptr + 3'd1;
              scan_cnt <= scan_cnt + 3'd1;
              if (scan_cnt == 3'd7) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end

          BOTTOM: begin
            // Grid position and bottom row are captured here, so grid motion
            // during the launch cycle does not affect the spawn point.
            state <= LAUNCH;
            if (slot_sel != '0) begin
              launch   <= slot_sel;
              launchX  <= spawn_x;
              launchY  <= spawn_y;
              cooldown <= CD_RELOAD;
            end
          end

          LAUNCH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : alien_fire_scheduler

// File: tb/tb_alien_fire_scheduler.sv
// Directed bench for alien_fire_scheduler: reset, launch timing and spawn
// position, column skipping, empty grid, slot handling, cooldown, playGame
// abort and reset during a scan.
module tb_alien_fire_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic               startOfFrame;
  logic               playGame;
  logic [31:0]        alienAlive;
  logic signed [10:0] gridX;
  logic signed [10:0] gridY;
  logic [1:0]         slotAlive;
  logic [1:0]         launch;
  logic signed [10:0] launchX;
  logic signed [10:0] launchY;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  // Reference random source: x^8+x^6+x^5+x^4+1, seed A5, one step per clock.
  logic [7:0] m_lfsr;

  alien_fire_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .playGame     (playGame),
    .alienAlive   (alienAlive),
    .gridX        (gridX),
    .gridY        (gridY),
    .slotAlive    (slotAlive),
    .launch       (launch),
    .launchX      (launchX),
    .launchY      (launchY),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // One frame pulse, then one quiet cycle.
  task automatic frame_gap();
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
  endtask

  // Bring cooldown to zero without starting a scan (all slots busy).
  task automatic drain();
    logic [1:0] saved;
    saved     = slotAlive;
    slotAlive = 2'b11;
    repeat (20) frame_gap();
    slotAlive = saved;
  endtask

  // Wait (bounded) until the LFSR low bits equal the wanted start column.
  task automatic wait_ptr(input logic [2:0] p);
    int n;
    n = 0;
    while ((m_lfsr[2:0] !== p) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_lfsr[2:0] !== p) begin
      failures++;
      $display("FAIL wait_ptr: lfsr[2:0]=%0d never reached %0d", m_lfsr[2:0], p);
    end
  endtask

  // Fire one qualifying frame and check latency, slot and spawn position.
  task automatic run_launch(input string name, input logic [2:0] ptr,
                            input logic [31:0] alive, input int gx, input int gy,
                            input logic [1:0] slots, input int exp_lat,
                            input logic [1:0] exp_launch, input int exp_x,
                            input int exp_y);
    int                 n;
    int                 lat;
    logic [1:0]         got_l;
    logic signed [10:0] got_x;
    logic signed [10:0] got_y;
    logic signed [10:0] want_x;
    logic signed [10:0] want_y;
    want_x     = 11'(exp_x);
    want_y     = 11'(exp_y);
    alienAlive = alive;
    gridX      = 11'(gx);
    gridY      = 11'(gy);
    slotAlive  = slots;
    wait_ptr(ptr);
    startOfFrame = 1'b1;
    n     = 0;
    lat   = 0;
    got_l = '0;
    got_x = '0;
    got_y = '0;
    while ((lat == 0) && (n < 20)) begin
      @(negedge clk);
      startOfFrame = 1'b0;
      n++;
      if (launch != 2'b00) begin
        lat   = n;
        got_l = launch;
        got_x = launchX;
        got_y = launchY;
      end
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, lat, exp_lat);
    end
    checks++;
    if (got_l !== exp_launch) begin
      failures++;
      $display("FAIL %s launch: got %b, want %b", name, got_l, exp_launch);
    end
    checks++;
    if (got_x !== want_x) begin
      failures++;
      $display("FAIL %s launchX: got %0d, want %0d", name, got_x, want_x);
    end
    checks++;
    if (got_y !== want_y) begin
      failures++;
      $display("FAIL %s launchY: got %0d, want %0d", name, got_y, want_y);
    end
    @(negedge clk);
    checks++;
    if (launch !== 2'b00) begin
      failures++;
      $display("FAIL %s pulse_width: launch=%b one cycle later, want 00", name, launch);
    end
  endtask

  // Observe n cycles, noting any launch or busy.
  task automatic watch(input int n, output logic saw_launch, output logic saw_busy);
    saw_launch = 1'b0;
    saw_busy   = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (launch != 2'b00) saw_launch = 1'b1;
      if (busy)            saw_busy   = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic sl, sb;
    reset = 1'b1;
    startOfFrame = 1'b0;
    playGame = 1'b1;
    alienAlive = '1;
    gridX = '0;
    gridY = '0;
    slotAlive = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (launch !== 2'b00) begin failures++; $display("FAIL reset_launch: got %b, want 00", launch); end
    checks++;
    if (launchX !== 11'sd0) begin failures++; $display("FAIL reset_launchX: got %0d, want 0", launchX); end
    checks++;
    if (launchY !== 11'sd0) begin failures++; $display("FAIL reset_launchY: got %0d, want 0", launchY); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, want 0", busy); end
    // Cooldown starts full, so a frame right after reset must not scan.
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    watch(4, sl, sb);
    checks++;
    if (sb !== 1'b0) begin failures++; $display("FAIL reset_cooldown: busy seen=%b, want 0", sb); end
  endtask

  task automatic test_full_grid();
    drain();
    run_launch("full_grid", 3'd3, 32'hFFFF_FFFF, 100, 50, 2'b00, 3, 2'b01, 323, 178);
  endtask

  task automatic test_skip_columns();
    drain();
    // Columns 3-5 empty, column 6 row 1, column 7 full.
    run_launch("skip3", 3'd3, 32'h8080_C080, 0, 0, 2'b00, 6, 2'b01, 415, 64);
    drain();
    // Only column 2 occupied: seven skips; X wraps past 11 bits (1159).
    run_launch("skip7_wrap", 3'd3, 32'h0404_0404, 1000, -40, 2'b00, 10, 2'b01, 1159, 88);
  endtask

  task automatic test_empty_grid();
    logic saw_l;
    logic b1, b8, b9;
    drain();
    alienAlive = '0;
    slotAlive  = 2'b00;
    startOfFrame = 1'b1;
    saw_l = 1'b0;
    b1 = 1'b0; b8 = 1'b0; b9 = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      startOfFrame = 1'b0;
      if (launch != 2'b00) saw_l = 1'b1;
      if (n == 1) b1 = busy;
      if (n == 8) b8 = busy;
      if (n == 9) b9 = busy;
    end
    checks++;
    if (b1 !== 1'b1) begin failures++; $display("FAIL empty_busy_start: got %b, want 1", b1); end
    checks++;
    if (b8 !== 1'b1) begin failures++; $display("FAIL empty_busy_col8: got %b, want 1", b8); end
    checks++;
    if (b9 !== 1'b0) begin failures++; $display("FAIL empty_busy_end: got %b, want 0", b9); end
    checks++;
    if (saw_l !== 1'b0) begin failures++; $display("FAIL empty_no_launch: launch seen=%b, want 0", saw_l); end
    // Cooldown untouched: next qualifying frame launches straight away.
    run_launch("after_empty", 3'd0, 32'hFFFF_FFFF, 0, 0, 2'b00, 3, 2'b01, 31, 128);
  endtask

  task automatic test_slots();
    logic sl, sb;
    drain();
    run_launch("slot1", 3'd7, 32'hFFFF_FFFF, 0, 0, 2'b01, 3, 2'b10, 479, 128);
    drain();
    // Both slots in flight: IDLE is never left.
    slotAlive = 2'b11;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    watch(5, sl, sb);
    checks++;
    if (sb !== 1'b0) begin failures++; $display("FAIL slots_full_idle: busy seen=%b, want 0", sb); end
    // Slots fill up while scanning: no launch and no cooldown reload.
    slotAlive  = 2'b00;
    alienAlive = 32'h0404_0404;
    wait_ptr(3'd3);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
    slotAlive = 2'b11;
    watch(12, sl, sb);
    checks++;
    if (sl !== 1'b0) begin failures++; $display("FAIL slots_rise_scan: launch seen=%b, want 0", sl); end
    run_launch("after_rise", 3'd1, 32'hFFFF_FFFF, 0, 0, 2'b00, 3, 2'b01, 95, 128);
  endtask

  task automatic test_cooldown();
    logic sb;
    logic b_after;
    // Previous launch reloaded cooldown: 20 frames must pass without a scan.
    alienAlive = '1;
    slotAlive  = 2'b00;
    sb = 1'b0;
    repeat (20) begin
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      if (busy) sb = 1'b1;
      @(negedge clk);
      if (busy) sb = 1'b1;
    end
    checks++;
    if (sb !== 1'b0) begin failures++; $display("FAIL cooldown_20: busy seen=%b, want 0", sb); end
    run_launch("cooldown_21st", 3'd4, 32'hFFFF_FFFF, 0, 0, 2'b00, 3, 2'b01, 287, 128);

    // playGame dropped mid-scan.
    drain();
    alienAlive = '0;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
    @(negedge clk);
    playGame = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL play_drop_idle: busy=%b, want 0", busy); end
    @(negedge clk);
    playGame = 1'b1;
    sb = 1'b0;
    repeat (20) begin
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      if (busy) sb = 1'b1;
      @(negedge clk);
      if (busy) sb = 1'b1;
    end
    checks++;
    if (sb !== 1'b0) begin failures++; $display("FAIL play_drop_reload: busy seen=%b, want 0", sb); end
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    b_after = busy;
    checks++;
    if (b_after !== 1'b1) begin failures++; $display("FAIL play_drop_21st: busy=%b, want 1", b_after); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_in_bottom();
    alienAlive = '1;
    slotAlive  = 2'b00;
    gridX      = 11'sd100;
    gridY      = 11'sd50;
    wait_ptr(3'd2);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (launch !== 2'b00) begin failures++; $display("FAIL rst_bottom_launch: got %b, want 00", launch); end
    checks++;
    if (launchX !== 11'sd0) begin failures++; $display("FAIL rst_bottom_launchX: got %0d, want 0", launchX); end
    checks++;
    if (launchY !== 11'sd0) begin failures++; $display("FAIL rst_bottom_launchY: got %0d, want 0", launchY); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_bottom_busy: got %b, want 0", busy); end
    // LFSR restarted at A5: the column chosen follows the restarted sequence.
    drain();
    run_launch("lfsr_restart", 3'd5, 32'hFFFF_FFFF, 0, 0, 2'b00, 3, 2'b01, 351, 128);
  endtask

  initial begin
    test_reset();
    test_full_grid();
    test_skip_columns();
    test_empty_grid();
    test_slots();
    test_cooldown();
    test_reset_in_bottom();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alien_fire_scheduler
